// File: rtl/boot_loader.sv
// Streams instruction words into instruction memory and holds the processor
// in reset until the whole image is written.
module boot_loader #(
    parameter int unsigned ADDR_W      = 6,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);

    localparam int unsigned HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [ADDR_W-1:0] PTR_ONE  = 1;
    localparam logic [ADDR_W:0]   CNT_ONE  = 1;
    localparam logic [HCW-1:0]    HOLD_ONE = 1;
    localparam logic [HCW-1:0]    HOLD_TOP = HCW'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, LOAD, HOLD, RUN, ERR} state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [HCW-1:0]    hold_cnt;
    logic              accept;

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            ptr        <= '0;
            hold_cnt   <= '0;
            in_ready   <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_rst    <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                IDLE, RUN, ERR: begin
                    if (start) begin
                        state      <= LOAD;
                        ptr        <= '0;
                        word_count <= '0;
                        in_ready   <= 1'b1;
                        cpu_rst    <= 1'b1;
                        done       <= 1'b0;
                        error      <= 1'b0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        mem_we     <= 1'b1;
                        mem_addr   <= ptr;
                        mem_wdata  <= in_data;
                        word_count <= word_count + CNT_ONE;
                        if (ptr != '1)
                            ptr <= ptr + PTR_ONE;
                        // in_last wins over overflow when the final slot holds the last word
                        if (in_last) begin
                            state    <= HOLD;
                            in_ready <= 1'b0;
                            hold_cnt <= HOLD_TOP;
                        end else if (ptr == '1) begin
                            state    <= ERR;
                            in_ready <= 1'b0;
                            error    <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (hold_cnt == '0) begin
                        state   <= RUN;
                        cpu_rst <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt - HOLD_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: a default-size instance for load/reload/reset
// scenarios and a 4-deep instance for the overflow case.
module tb_boot_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, start2;
    logic        in_valid, in_last;
    logic [31:0] in_data;

    logic        in_ready, mem_we, cpu_rst, done, error;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [6:0]  word_count;

    logic        in_ready2, mem_we2, cpu_rst2, done2, error2;
    logic [1:0]  mem_addr2;
    logic [31:0] mem_wdata2;
    logic [2:0]  word_count2;

    int nvec = 0;
    int nerr = 0;
    int wr_cnt = 0;
    int wr_base;
    logic [31:0] img [0:63];

    localparam logic [31:0] W0 = 32'hE3A00005;
    localparam logic [31:0] W1 = 32'hE3A01006;
    localparam logic [31:0] W2 = 32'hE0808001;
    localparam logic [31:0] WB = 32'hEAFFFFFE;

    always #5 clk = ~clk;

    boot_loader #(.ADDR_W(6), .DATA_W(32), .HOLD_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_rst(cpu_rst), .done(done), .error(error), .word_count(word_count)
    );

    boot_loader #(.ADDR_W(2), .DATA_W(32), .HOLD_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .in_valid(in_valid),
        .in_data(in_data), .in_last(in_last), .in_ready(in_ready2),
        .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
        .cpu_rst(cpu_rst2), .done(done2), .error(error2), .word_count(word_count2)
    );

    always @(posedge clk) begin
        if (mem_we === 1'b1) begin
            img[mem_addr] <= mem_wdata;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start2 = 1'b0;
        in_valid = 1'b0; in_last = 1'b0; in_data = '0;
        #1 rst = 1'b0;
        #2;
        chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_count", 32'(word_count), 32'd0);
        step(); step();
        rst = 1'b1;
        step();

        // Basic load
        start = 1'b1; step(); start = 1'b0;
        chk("bl_ready", 32'(in_ready), 32'd1);
        chk("bl_we0", 32'(mem_we), 32'd0);
        in_valid = 1'b1; in_data = W0; step();
        chk("bl_we_a", 32'(mem_we), 32'd1);
        chk("bl_addr_a", 32'(mem_addr), 32'd0);
        chk("bl_data_a", mem_wdata, W0);
        chk("bl_cnt_a", 32'(word_count), 32'd1);
        in_data = W1; step();
        chk("bl_addr_b", 32'(mem_addr), 32'd1);
        chk("bl_data_b", mem_wdata, W1);
        in_data = W2; in_last = 1'b1; step();
        chk("bl_we_c", 32'(mem_we), 32'd1);
        chk("bl_addr_c", 32'(mem_addr), 32'd2);
        chk("bl_data_c", mem_wdata, W2);
        chk("bl_cnt_c", 32'(word_count), 32'd3);
        chk("bl_ready_low", 32'(in_ready), 32'd0);
        in_valid = 1'b0; in_last = 1'b0; step();
        chk("bl_hold_we", 32'(mem_we), 32'd0);
        chk("bl_hold_cpu", 32'(cpu_rst), 32'd1);
        chk("bl_hold_done", 32'(done), 32'd0);
        step();
        chk("bl_run_cpu", 32'(cpu_rst), 32'd0);
        chk("bl_run_done", 32'(done), 32'd1);
        chk("bl_addr_held", 32'(mem_addr), 32'd2);
        chk("bl_img0", img[0], W0);
        chk("bl_img2", img[2], W2);

        // Reload from RUN; start with in_valid in RUN must not accept a beat
        start = 1'b1; in_valid = 1'b1; in_data = 32'hDEADBEEF; in_last = 1'b1; step();
        start = 1'b0;
        chk("rl_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("rl_done", 32'(done), 32'd0);
        chk("rl_no_we", 32'(mem_we), 32'd0);
        chk("rl_cnt0", 32'(word_count), 32'd0);
        chk("rl_ready", 32'(in_ready), 32'd1);
        in_data = WB; step();
        chk("rl_we", 32'(mem_we), 32'd1);
        chk("rl_addr", 32'(mem_addr), 32'd0);
        chk("rl_data", mem_wdata, WB);
        chk("rl_cnt", 32'(word_count), 32'd1);
        in_valid = 1'b0; in_last = 1'b0; step();
        chk("rl_hold", 32'(cpu_rst), 32'd1);
        step();
        chk("rl_run", 32'(cpu_rst), 32'd0);
        chk("rl_done1", 32'(done), 32'd1);

        // Gapped stream plus ignored start in LOAD and HOLD
        start = 1'b1; step(); start = 1'b0;
        wr_base = wr_cnt;
        in_valid = 1'b1; in_data = W0; step();
        chk("gp_addr_a", 32'(mem_addr), 32'd0);
        in_valid = 1'b0; start = 1'b1; step(); start = 1'b0;
        chk("gp_gap_we", 32'(mem_we), 32'd0);
        chk("gp_gap_cnt", 32'(word_count), 32'd1);
        chk("gp_gap_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_data = W1; step();
        chk("gp_addr_b", 32'(mem_addr), 32'd1);
        chk("gp_cnt_b", 32'(word_count), 32'd2);
        in_valid = 1'b0; step();
        chk("gp_gap2_we", 32'(mem_we), 32'd0);
        in_valid = 1'b1; in_data = W2; in_last = 1'b1; step();
        chk("gp_addr_c", 32'(mem_addr), 32'd2);
        chk("gp_cnt_c", 32'(word_count), 32'd3);
        in_valid = 1'b0; in_last = 1'b0; start = 1'b1; step(); start = 1'b0;
        chk("gp_hold_cpu", 32'(cpu_rst), 32'd1);
        chk("gp_hold_ready", 32'(in_ready), 32'd0);
        step();
        chk("gp_run_cpu", 32'(cpu_rst), 32'd0);
        chk("gp_run_done", 32'(done), 32'd1);
        chk("gp_cnt_final", 32'(word_count), 32'd3);
        chk("gp_writes", 32'(wr_cnt - wr_base), 32'd3);
        chk("gp_img0", img[0], W0);
        chk("gp_img1", img[1], W1);
        chk("gp_img2", img[2], W2);

        // Reset mid-load after two accepted beats
        start = 1'b1; step(); start = 1'b0;
        in_valid = 1'b1; in_data = 32'h11111111; step();
        in_data = 32'h22222222; step();
        wr_base = wr_cnt;
        #3 rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("mr_we", 32'(mem_we), 32'd0);
        chk("mr_ready", 32'(in_ready), 32'd0);
        chk("mr_cpu", 32'(cpu_rst), 32'd1);
        chk("mr_addr", 32'(mem_addr), 32'd0);
        chk("mr_wdata", mem_wdata, 32'd0);
        chk("mr_cnt", 32'(word_count), 32'd0);
        chk("mr_done", 32'(done), 32'd0);
        step(); step();
        chk("mr_no_write", 32'(wr_cnt - wr_base), 32'd0);
        rst = 1'b1; step();
        start = 1'b1; step(); start = 1'b0;
        in_valid = 1'b1; in_data = 32'hA0000000; step();
        chk("mr_re_addr0", 32'(mem_addr), 32'd0);
        chk("mr_re_data0", mem_wdata, 32'hA0000000);
        in_data = 32'hA0000001; step();
        in_data = 32'hA0000002; step();
        in_data = 32'hA0000003; in_last = 1'b1; step();
        chk("mr_re_addr3", 32'(mem_addr), 32'd3);
        chk("mr_re_cnt", 32'(word_count), 32'd4);
        in_valid = 1'b0; in_last = 1'b0; step(); step();
        chk("mr_re_done", 32'(done), 32'd1);

        // Overflow on the 4-deep instance
        start2 = 1'b1; step(); start2 = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_data = 32'hC0DE0000 + 32'(k); step();
            chk("ov_we", 32'(mem_we2), 32'd1);
            chk("ov_addr", 32'(mem_addr2), 32'(k));
            chk("ov_data", mem_wdata2, 32'hC0DE0000 + 32'(k));
            chk("ov_cnt", 32'(word_count2), 32'(k + 1));
        end
        chk("ov_error", 32'(error2), 32'd1);
        chk("ov_ready", 32'(in_ready2), 32'd0);
        chk("ov_cpu", 32'(cpu_rst2), 32'd1);
        in_data = 32'hC0DE0004; step();
        chk("ov_5th_we", 32'(mem_we2), 32'd0);
        chk("ov_5th_cnt", 32'(word_count2), 32'd4);
        chk("ov_5th_err", 32'(error2), 32'd1);
        chk("ov_5th_done", 32'(done2), 32'd0);
        chk("ov_5th_cpu", 32'(cpu_rst2), 32'd1);
        in_valid = 1'b0; start2 = 1'b1; step(); start2 = 1'b0;
        chk("ov_restart_err", 32'(error2), 32'd0);
        chk("ov_restart_ready", 32'(in_ready2), 32'd1);
        chk("ov_restart_cnt", 32'(word_count2), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
